// File: rtl/uart_controller.sv
// rtl/uart_controller.sv - bus-facing UART controller with TX/RX FIFOs
// Contains the bit-level transmitter and receiver it sequences.
module uart_transmitter #(
    parameter int ClkFrequency = 25000000,
    parameter int Baud = 115200
) (
    input  logic       clk,
    input  logic       TxD_start,
    input  logic [7:0] TxD_data,
    output logic       TxD,
    output logic       TxD_busy
);
    localparam int Div = ClkFrequency / Baud;
    localparam int CntW = $clog2(Div + 1);
    localparam logic [1:0] TX_IDLE = 2'd0, TX_START = 2'd1, TX_DATA = 2'd2, TX_STOP = 2'd3;

    // No reset: the all-zero state is idle, so a byte in flight always finishes.
    logic [1:0] state;
    logic [CntW-1:0] baudCnt;
    logic [2:0] bitCnt;
    logic [7:0] shift;
    logic tick;

    assign tick = baudCnt == CntW'(Div - 1);
    assign TxD_busy = state != TX_IDLE;

    always_ff @(posedge clk) begin
        if (state == TX_IDLE) begin
            if (TxD_start) begin
                state <= TX_START;
                shift <= TxD_data;
                baudCnt <= '0;
                bitCnt <= '0;
            end
        end else begin
            baudCnt <= tick ? '0 : baudCnt + 1'b1;
            if (tick) begin
                case (state)
                    TX_START: state <= TX_DATA;
                    TX_DATA: begin
                        shift <= shift >> 1;
                        bitCnt <= bitCnt + 1'b1;
                        if (bitCnt == 3'd7) state <= TX_STOP;
                    end
                    default: state <= TX_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        TxD = 1'b1;
        if (state == TX_START) TxD = 1'b0;
        else if (state == TX_DATA) TxD = shift[0];
    end
endmodule

module uart_receiver #(
    parameter int ClkFrequency = 25000000,
    parameter int Baud = 115200
) (
    input  logic       clk,
    input  logic       RxD,
    input  logic       RxD_clear,
    output logic       RxD_data_ready,
    output logic [7:0] RxD_data
);
    localparam int Div = ClkFrequency / Baud;
    localparam int CntW = $clog2(Div + 1);
    localparam logic [1:0] RX_IDLE = 2'd0, RX_START = 2'd1, RX_DATA = 2'd2, RX_STOP = 2'd3;

    logic [1:0] state;
    logic [CntW-1:0] baudCnt;
    logic [2:0] bitCnt;
    logic [7:0] shift;
    logic rxS1, rxS2, rxPrev;
    logic tick;

    assign tick = baudCnt == CntW'(Div - 1);

    always_ff @(posedge clk) begin
        rxS1 <= RxD;
        rxS2 <= rxS1;
        rxPrev <= rxS2;
        RxD_data_ready <= 1'b0;
        baudCnt <= tick ? '0 : baudCnt + 1'b1;
        case (state)
            RX_IDLE: if (rxPrev && !rxS2) begin
                state <= RX_START;
                baudCnt <= '0;
            end
            // Half a bit into the start bit re-aligns sampling to mid-bit.
            RX_START: if (baudCnt == CntW'(Div / 2 - 1)) begin
                state <= rxS2 ? RX_IDLE : RX_DATA;
                baudCnt <= '0;
                bitCnt <= '0;
            end
            RX_DATA: if (tick) begin
                shift <= {rxS2, shift[7:1]};
                bitCnt <= bitCnt + 1'b1;
                if (bitCnt == 3'd7) state <= RX_STOP;
            end
            default: if (tick) begin
                state <= RX_IDLE;
                if (rxS2) begin
                    RxD_data <= shift;
                    RxD_data_ready <= 1'b1;
                end
            end
        endcase
        if (RxD_clear) state <= RX_IDLE;
    end
endmodule

module uart_controller #(
    parameter int ClkFrequency = 25000000,
    parameter int Baud = 115200,
    parameter int TxDepth = 16,
    parameter int RxDepth = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bus_en,
    input  logic       bus_we,
    input  logic       bus_addr,
    input  logic [7:0] bus_wdata,
    output logic [7:0] bus_rdata,
    output logic       txd,
    input  logic       rxd,
    output logic       irq
);
    localparam int TxAw = $clog2(TxDepth);
    localparam int RxAw = $clog2(RxDepth);
    localparam logic [1:0] IDLE = 2'd0, WAIT_BUSY = 2'd1, WAIT_DONE = 2'd2;

    logic [7:0] txMem [TxDepth];
    logic [7:0] rxMem [RxDepth];
    logic [TxAw:0] txWr, txRd;
    logic [RxAw:0] rxWr, rxRd;
    logic txFull, txEmpty, rxFull, rxEmpty;
    logic txPush, rxPush, rxPop, statusRead;
    logic [1:0] state;
    logic txStart, txBusy, txIdle, overrun;
    logic rxDataReady;
    logic [7:0] rxData;

    assign txFull = (txWr[TxAw] != txRd[TxAw]) && (txWr[TxAw-1:0] == txRd[TxAw-1:0]);
    assign txEmpty = txWr == txRd;
    assign rxFull = (rxWr[RxAw] != rxRd[RxAw]) && (rxWr[RxAw-1:0] == rxRd[RxAw-1:0]);
    assign rxEmpty = rxWr == rxRd;

    assign txPush = bus_en && bus_we && !bus_addr && !txFull;
    assign rxPush = rxDataReady && !rxFull;
    assign rxPop = bus_en && !bus_we && !bus_addr && !rxEmpty;
    assign statusRead = bus_en && !bus_we && bus_addr;
    assign txStart = (state == IDLE) && !txEmpty && !txBusy;
    assign txIdle = txEmpty && (state == IDLE) && !txBusy;
    assign irq = !rxEmpty;

    always_ff @(posedge clk) begin
        if (txPush) txMem[txWr[TxAw-1:0]] <= bus_wdata;
        if (rxPush) rxMem[rxWr[RxAw-1:0]] <= rxData;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            txWr <= '0;
            txRd <= '0;
            rxWr <= '0;
            rxRd <= '0;
            overrun <= 1'b0;
            state <= IDLE;
            bus_rdata <= 8'h00;
        end else begin
            if (txPush) txWr <= txWr + 1'b1;
            if (txStart) txRd <= txRd + 1'b1;
            if (rxPush) rxWr <= rxWr + 1'b1;
            if (rxPop) rxRd <= rxRd + 1'b1;
            // A fresh overrun wins over the clear-on-read.
            if (rxDataReady && rxFull) overrun <= 1'b1;
            else if (statusRead) overrun <= 1'b0;
            if (bus_en && !bus_we) begin
                if (bus_addr) bus_rdata <= {4'b0, overrun, txIdle, !rxEmpty, !txFull};
                else bus_rdata <= rxEmpty ? 8'h00 : rxMem[rxRd[RxAw-1:0]];
            end
            case (state)
                IDLE: if (txStart) state <= WAIT_BUSY;
                WAIT_BUSY: if (txBusy) state <= WAIT_DONE;
                WAIT_DONE: if (!txBusy) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    uart_transmitter #(.ClkFrequency(ClkFrequency), .Baud(Baud)) u_tx (
        .clk(clk),
        .TxD_start(txStart),
        .TxD_data(txMem[txRd[TxAw-1:0]]),
        .TxD(txd),
        .TxD_busy(txBusy)
    );

    uart_receiver #(.ClkFrequency(ClkFrequency), .Baud(Baud)) u_rx (
        .clk(clk),
        .RxD(rxd),
        .RxD_clear(1'b0),
        .RxD_data_ready(rxDataReady),
        .RxD_data(rxData)
    );
endmodule

// File: tb/tb_uart_controller.sv
// tb/tb_uart_controller.sv - scoreboard bench for uart_controller
module tb_uart_controller;
    localparam int ClkHz = 1152000;
    localparam int BaudRate = 115200;
    localparam int BitClks = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bus_en = 1'b0;
    logic bus_we = 1'b0;
    logic bus_addr = 1'b0;
    logic [7:0] bus_wdata = 8'h00;
    logic [7:0] bus_rdata;
    logic txd, rxd, irq;
    logic loopback = 1'b0;

    int checks = 0;
    int errors = 0;
    int startCount = 0;
    logic [7:0] txExp[$];
    logic [7:0] rxExp[$];

    assign rxd = loopback ? txd : 1'b1;

    uart_controller #(
        .ClkFrequency(ClkHz), .Baud(BaudRate), .TxDepth(4), .RxDepth(4)
    ) dut (
        .clk(clk), .rst(rst), .bus_en(bus_en), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .txd(txd), .rxd(rxd), .irq(irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (dut.txStart) startCount <= startCount + 1;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Callers start on a negedge; consecutive calls give back-to-back accesses.
    task automatic busWrite(input logic a, input logic [7:0] d);
        bus_en = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
        @(negedge clk);
        bus_en = 1'b0; bus_we = 1'b0;
    endtask

    task automatic busRead(input logic a, output logic [7:0] d);
        bus_en = 1'b1; bus_we = 1'b0; bus_addr = a;
        @(negedge clk);
        bus_en = 1'b0;
        d = bus_rdata;
    endtask

    task automatic sendByte(input logic [7:0] d, input logic toRx);
        txExp.push_back(d);
        if (toRx) rxExp.push_back(d);
        busWrite(1'b0, d);
    endtask

    task automatic waitTxDrain(input string tag);
        int n = 0;
        while (txExp.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkVal({tag, " tx drain"}, 32'(n < 3000), 32'd1);
        repeat (20) @(negedge clk);
    endtask

    task automatic waitIrq(input string tag);
        int n = 0;
        while (irq !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkVal({tag, " irq rise"}, 32'(irq), 32'd1);
    endtask

    initial begin : txMonitor
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (txd === 1'b0) begin
                repeat (BitClks / 2 - 1) @(negedge clk);
                checkVal("tx start bit", 32'(txd), 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (BitClks) @(negedge clk);
                    b[i] = txd;
                end
                repeat (BitClks) @(negedge clk);
                checkVal("tx stop bit", 32'(txd), 32'd1);
                if (txExp.size() == 0) checkVal("tx unexpected frame", {24'h0, b}, 32'hFFFF_FFFF);
                else checkVal("tx frame", 32'(b), 32'(txExp.pop_front()));
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] d;
        int s0, n;
        repeat (3) @(negedge clk);
        checkVal("reset rdata", 32'(bus_rdata), 32'h00);
        checkVal("reset irq", 32'(irq), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        busRead(1'b1, d); checkVal("status after reset", 32'(d), 32'h05);

        busRead(1'b0, d); checkVal("empty data read", 32'(d), 32'h00);
        busRead(1'b1, d); checkVal("status after empty read", 32'(d), 32'h05);

        s0 = startCount;
        sendByte(8'h55, 1'b0); sendByte(8'hA3, 1'b0); sendByte(8'h00, 1'b0);
        busRead(1'b1, d); checkVal("status during burst", 32'(d), 32'h01);
        waitTxDrain("burst");
        checkVal("burst start pulses", 32'(startCount - s0), 32'd3);
        busRead(1'b1, d); checkVal("status after burst", 32'(d), 32'h05);

        s0 = startCount;
        for (int i = 1; i <= 5; i++) sendByte(8'(i), 1'b0);
        busWrite(1'b0, 8'h06);
        busRead(1'b1, d); checkVal("status tx full", 32'(d), 32'h00);
        waitTxDrain("overflow");
        checkVal("overflow start pulses", 32'(startCount - s0), 32'd5);

        loopback = 1'b1;
        repeat (2) @(negedge clk);
        sendByte(8'h3C, 1'b1);
        waitIrq("loopback");
        busRead(1'b0, d); checkVal("loopback data", 32'(d), 32'(rxExp.pop_front()));
        checkVal("loopback irq clear", 32'(irq), 32'd0);
        busRead(1'b1, d); checkVal("loopback rx_nonempty", 32'(d[1]), 32'd0);
        waitTxDrain("loopback");

        sendByte(8'h11, 1'b1);
        waitIrq("same-cycle");
        sendByte(8'h22, 1'b0);
        n = 0;
        while (dut.rxDataReady !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        bus_en = 1'b1; bus_we = 1'b0; bus_addr = 1'b0;
        @(negedge clk);
        bus_en = 1'b0;
        checkVal("same-cycle old head", 32'(bus_rdata), 32'(rxExp.pop_front()));
        rxExp.push_back(8'h22);
        checkVal("same-cycle irq held", 32'(irq), 32'd1);
        busRead(1'b0, d); checkVal("same-cycle new head", 32'(d), 32'(rxExp.pop_front()));
        checkVal("same-cycle irq clear", 32'(irq), 32'd0);
        waitTxDrain("same-cycle");

        sendByte(8'hA1, 1'b1); sendByte(8'hB2, 1'b1); sendByte(8'hC3, 1'b1);
        sendByte(8'hD4, 1'b1); sendByte(8'hE5, 1'b0);
        waitTxDrain("overrun");
        busRead(1'b1, d); checkVal("overrun status", 32'(d), 32'h0F);
        busRead(1'b1, d); checkVal("overrun cleared", 32'(d), 32'h07);
        for (int i = 0; i < 4; i++) begin
            busRead(1'b0, d); checkVal("overrun data", 32'(d), 32'(rxExp.pop_front()));
        end
        busRead(1'b1, d); checkVal("status after drain", 32'(d), 32'h05);

        sendByte(8'h5A, 1'b1);
        waitIrq("reset pending");
        waitTxDrain("reset pending");
        loopback = 1'b0;
        sendByte(8'hAA, 1'b0);
        n = 0;
        while (txd !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (30) @(negedge clk);
        s0 = startCount;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rxExp.delete();
        checkVal("reset in flight rdata", 32'(bus_rdata), 32'h00);
        checkVal("reset in flight irq", 32'(irq), 32'd0);
        busRead(1'b1, d); checkVal("status in flight", 32'(d), 32'h01);
        waitTxDrain("reset in flight");
        checkVal("no start after reset", 32'(startCount - s0), 32'd0);
        busRead(1'b1, d); checkVal("status after flight", 32'(d), 32'h05);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
